// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM states, queue entry layout,
// the default reset PC and a word-alignment helper.
package fetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {inst, pc} entries with push, pop and flush.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic                       i_flush,
  input  fetch_entry_t               i_din,
  output fetch_entry_t               o_dout,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  fetch_entry_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr[AW-1:0]] <= i_din;
        r_wr                <= r_wr + 1'b1;
      end
      if (i_pop) r_rd <= r_rd + 1'b1;
    end
  end

  assign o_dout  = r_mem[r_rd[AW-1:0]];
  assign o_count = r_wr - r_rd;
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, keeps one imem request in flight,
// buffers returned words and handles redirects. FETCHQ_BYPASS_EN adds an ack->inst bypass.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         imem_req,
  output logic [31:0]                  imem_addr,
  input  logic                         imem_ack,
  input  logic [31:0]                  imem_rdata,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [31:0]                  inst_pc,
  input  logic                         inst_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output fetch_state_t                 dbg_state
);

  localparam int                CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);

  fetch_state_t  r_state, w_state_nxt;
  logic          r_req;
  logic [31:0]   r_addr;
  logic [31:0]   r_target;

  logic          w_ack, w_run, w_bypass, w_push, w_pop;
  logic          w_empty, w_full;
  logic [31:0]   w_rpc;
  logic [CW-1:0] w_count, w_count_post;
  fetch_entry_t  w_head;

  // Handshakes: imem transfer when imem_req & imem_ack; core pop when inst_valid & inst_ready.
  assign w_ack        = r_req & imem_ack;
  assign w_rpc        = align_pc(redirect_pc);
  assign w_count_post = w_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (redirect && r_req && !imem_ack) w_state_nxt = DRAIN;
      DRAIN:   if (w_ack) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_comb begin
    w_run = (r_state == RUN);
`ifdef FETCHQ_BYPASS_EN
    w_bypass = w_run & w_empty & ~redirect & w_ack;
`else
    w_bypass = 1'b0;
`endif
    w_pop      = w_run & ~redirect & ~w_empty & inst_ready;
    w_push     = w_run & ~redirect & w_ack & ~(w_bypass & inst_ready);
    inst_valid = w_run & (~w_empty | w_bypass);
    inst       = w_bypass ? imem_rdata : w_head.inst;
    inst_pc    = w_bypass ? r_addr     : w_head.pc;
  end

  // A request is only launched with a free slot, so its ack can always be stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req    <= 1'b0;
      r_addr   <= RESET_PC;
      r_target <= RESET_PC;
    end else if (r_state == RUN) begin
      if (redirect) begin
        r_target <= w_rpc;
        if (!r_req || imem_ack) begin
          r_req  <= 1'b1;
          r_addr <= w_rpc;
        end
      end else if (w_ack) begin
        r_addr <= r_addr + 32'd4;
        r_req  <= (w_count_post < DEPTH_C);
      end else if (!r_req) begin
        r_req <= ~w_full;
      end
    end else begin
      if (redirect) r_target <= w_rpc;
      if (w_ack) begin
        r_req  <= 1'b1;
        r_addr <= redirect ? w_rpc : r_target;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_din   ('{inst: imem_rdata, pc: r_addr}),
    .o_dout  (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign count     = w_count;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a queue-based reference model of the
// fetch/redirect/drain rules, with directed phases for fill, redirect and wrap.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCHQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk, rst;
  logic         imem_req, imem_ack, redirect, inst_valid, inst_ready;
  logic [31:0]  imem_addr, imem_rdata, redirect_pc, inst, inst_pc;
  logic [2:0]   count;
  fetch_state_t dbg_state;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic        m_req, m_drain;
  logic [31:0] m_addr, m_target;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_pc_q.delete();
    m_req    = 1'b0;
    m_drain  = 1'b0;
    m_addr   = RESET_PC;
    m_target = RESET_PC;
  endtask

  // Reset asserted mid-cycle, checked immediately, released just after an edge.
  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    imem_ack = 1'b1;
    #1;
    model_reset();
    check("rst_req",   imem_req,   0);
    check("rst_addr",  imem_addr,  RESET_PC);
    check("rst_valid", inst_valid, 0);
    check("rst_inst",  inst,       0);
    check("rst_pc",    inst_pc,    0);
    check("rst_count", count,      0);
    check("rst_state", dbg_state,  RUN);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // driver: one clock cycle of stimulus, check, then model update at the edge
  task automatic cycle(input bit ack, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          m_ack, byp, exp_valid;
    int          sz0;
    logic [31:0] rdat;
    @(negedge clk);
    rdat        = $urandom;
    imem_ack    = ack;
    inst_ready  = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_rdata  = rdat;
    #1;
    m_ack     = m_req & ack;
    byp       = BYP && !m_drain && exp_q.size() == 0 && m_ack && !redir;
    exp_valid = !m_drain && (exp_q.size() > 0 || byp);
    check("req",   imem_req,   m_req);
    check("addr",  imem_addr,  m_addr);
    check("count", count,      exp_q.size());
    check("state", dbg_state,  m_drain ? DRAIN : RUN);
    check("valid", inst_valid, exp_valid);
    if (exp_valid) begin
      check("inst",    inst,    exp_q.size() > 0 ? exp_q[0]    : rdat);
      check("inst_pc", inst_pc, exp_q.size() > 0 ? exp_pc_q[0] : m_addr);
    end
    @(posedge clk);
    if (!m_drain) begin
      if (redir) begin
        exp_q.delete();
        exp_pc_q.delete();
        if (!m_req || ack) begin
          m_req  = 1'b1;
          m_addr = {rpc[31:2], 2'b00};
        end else begin
          m_drain  = 1'b1;
          m_target = {rpc[31:2], 2'b00};
        end
      end else begin
        sz0 = exp_q.size();
        if (sz0 > 0 && rdy) begin
          void'(exp_q.pop_front());
          void'(exp_pc_q.pop_front());
        end
        if (m_ack && !(byp && rdy)) begin
          exp_q.push_back(rdat);
          exp_pc_q.push_back(m_addr);
        end
        if (m_ack) begin
          m_addr = m_addr + 32'd4;
          m_req  = exp_q.size() < DEPTH;
        end else if (!m_req) begin
          m_req = sz0 < DEPTH;
        end
      end
    end else begin
      if (redir) m_target = {rpc[31:2], 2'b00};
      if (m_ack) begin
        m_drain = 1'b0;
        m_req   = 1'b1;
        m_addr  = m_target;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 3))
      0:       return 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      1:       return 32'h0000_0400;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = '0; redirect = 1'b0;
    redirect_pc = '0; inst_ready = 1'b0;
    model_reset();
    do_reset();

    // sustained zero-wait stream
    repeat (20) cycle(1, 1, 0, 0);
    // fill with consumer stalled, then one pop and idle to watch req return
    repeat (10) cycle(1, 0, 0, 0);
    cycle(1, 1, 0, 0);
    repeat (3) cycle(0, 0, 0, 0);
    repeat (3) cycle(1, 1, 0, 0);
    // redirect while a request waits, ack held low, then completes
    cycle(0, 1, 1, 32'h0000_0400);
    repeat (3) cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    repeat (4) cycle(1, 1, 0, 0);
    // redirect coincident with ack and pop
    cycle(1, 0, 0, 0);
    cycle(1, 1, 1, 32'h0000_0123);
    repeat (3) cycle(1, 1, 0, 0);
    // address wrap
    cycle(1, 1, 1, 32'hFFFF_FFFE);
    repeat (4) cycle(1, 1, 0, 0);
    // redirect inside DRAIN
    cycle(0, 1, 1, 32'h0000_0800);
    cycle(0, 1, 1, 32'h0000_0900);
    cycle(1, 1, 1, 32'h0000_0A00);
    repeat (3) cycle(1, 1, 0, 0);
    // reset with entries queued and a request outstanding
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    do_reset();
    repeat (6) cycle(1, 1, 0, 0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 8, rand_pc());
      if (i == 300) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
